// File: rtl/fa_add.sv
// WIDTH-bit ripple-carry adder (two half adders + OR per bit) with zero-latency comb outputs
// and a 1-cycle registered copy that loads on in_valid; no backpressure.
module fa_add #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_q,
  output logic             out_valid
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g1;
  logic [WIDTH-1:0] g2;

  assign c[0]  = cin;
  assign carry = c[WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign p[i]   = a[i] ^ b[i];
    assign g1[i]  = a[i] & b[i];
    assign sum[i] = p[i] ^ c[i];
    assign g2[i]  = p[i] & c[i];
    assign c[i+1] = g1[i] | g2[i];
  end

  // Result registers hold across idle cycles; only the valid flag tracks every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q     <= '0;
      carry_q   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum_q   <= sum;
        carry_q <= carry;
      end
    end
  end

endmodule

// File: tb/tb_fa_add.sv
module tb_fa_add;

  logic       clk;
  logic       rst_n;

  logic       a1, b1, cin1, iv1;
  logic       sum1, carry1, sq1, cq1, ov1;

  logic [7:0] a8, b8;
  logic       cin8, iv8;
  logic [7:0] sum8, sq8;
  logic       carry8, cq8, ov8;

  int n_checks;
  int n_fail;

  logic [8:0] sb_q[$];
  logic [8:0] last_res;

  fa_add #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin1), .in_valid(iv1),
    .sum(sum1), .carry(carry1), .sum_q(sq1), .carry_q(cq1), .out_valid(ov1)
  );

  fa_add #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8), .in_valid(iv8),
    .sum(sum8), .carry(carry8), .sum_q(sq8), .carry_q(cq8), .out_valid(ov8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    rst_n = 1'b1;
    a1 = 0; b1 = 0; cin1 = 0; iv1 = 0;
    a8 = 0; b8 = 0; cin8 = 0; iv8 = 0;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({sq1, cq1, ov1} !== 3'b000) begin
      n_fail++; $display("FAIL reset_w1 got=%b want=000", {sq1, cq1, ov1});
    end
    n_checks++;
    if ({sq8, cq8, ov8} !== 10'h000) begin
      n_fail++; $display("FAIL reset_w8 got sq=%h cq=%b ov=%b want 00/0/0", sq8, cq8, ov8);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_truth_table();
    logic [1:0] exp_sc [8];
    exp_sc = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01, 2'b11};
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      {a1, b1, cin1} = v;
      #1;
      n_checks++;
      if ({sum1, carry1} !== exp_sc[i]) begin
        n_fail++; $display("FAIL truth_%0d got=%b want=%b", i, {sum1, carry1}, exp_sc[i]);
      end
      #4;
    end
  endtask

  task automatic test_reg_w1();
    @(negedge clk);
    a1 = 1; b1 = 1; cin1 = 1; iv1 = 1;
    @(posedge clk); #1;
    n_checks++;
    if ({sq1, cq1, ov1} !== 3'b111) begin
      n_fail++; $display("FAIL reg_w1 got=%b want=111", {sq1, cq1, ov1});
    end
    @(negedge clk);
    iv1 = 0;
  endtask

  task automatic test_boundary_w8();
    logic [7:0] ta [4];
    logic [7:0] tb [4];
    logic       tc [4];
    logic [8:0] te [4];
    ta = '{8'hFF, 8'h5A, 8'hFF, 8'h00};
    tb = '{8'h00, 8'hA5, 8'hFF, 8'h00};
    tc = '{1'b1,  1'b0,  1'b1,  1'b0};
    te = '{9'h100, 9'h0FF, 9'h1FF, 9'h000};
    for (int i = 0; i < 4; i++) begin
      a8 = ta[i]; b8 = tb[i]; cin8 = tc[i];
      #1;
      n_checks++;
      if ({carry8, sum8} !== te[i]) begin
        n_fail++; $display("FAIL boundary_%0d got=%h want=%h", i, {carry8, sum8}, te[i]);
      end
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h00; cin8 = 0; iv8 = 1;
    @(posedge clk); #1;
    n_checks++;
    if ({ov8, cq8, sq8} !== 10'h212) begin
      n_fail++; $display("FAIL hold_capture got ov=%b cq=%b sq=%h want 1/0/12", ov8, cq8, sq8);
    end
    @(negedge clk);
    a8 = 8'h34; b8 = 8'hF0; cin8 = 1; iv8 = 0;
    @(posedge clk); #1;
    n_checks++;
    if ({ov8, cq8, sq8} !== 10'h012) begin
      n_fail++; $display("FAIL hold_idle got ov=%b cq=%b sq=%h want 0/0/12", ov8, cq8, sq8);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    a8 = 8'hF7; b8 = 8'h18; cin8 = 1; iv8 = 1;
    @(posedge clk); #1;
    n_checks++;
    if ({ov8, cq8, sq8} !== 10'h310) begin
      n_fail++; $display("FAIL pre_reset got ov=%b cq=%b sq=%h want 1/1/10", ov8, cq8, sq8);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ov8, cq8, sq8} !== 10'h000) begin
      n_fail++; $display("FAIL async_reset got ov=%b cq=%b sq=%h want 0/0/00", ov8, cq8, sq8);
    end
    n_checks++;
    if ({carry8, sum8} !== 9'h110) begin
      n_fail++; $display("FAIL comb_in_reset got=%h want=110", {carry8, sum8});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({ov8, cq8, sq8} !== 10'h000) begin
      n_fail++; $display("FAIL reset_held got ov=%b cq=%b sq=%h want 0/0/00", ov8, cq8, sq8);
    end
    @(negedge clk);
    iv8 = 0;
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [8:0] exp;
    logic       exp_ov;
    last_res = 9'h000;
    for (int n = 0; n < 1200; n++) begin
      @(negedge clk);
      a8   = 8'($urandom);
      b8   = 8'($urandom);
      cin8 = 1'($urandom);
      iv8  = ($urandom_range(0, 3) != 0);
      exp  = {1'b0, a8} + {1'b0, b8} + {8'h00, cin8};
      exp_ov = iv8;
      if (iv8) sb_q.push_back(exp);
      #1;
      n_checks++;
      if ({carry8, sum8} !== exp) begin
        n_fail++; $display("FAIL rand_comb a=%h b=%h c=%b got=%h want=%h", a8, b8, cin8, {carry8, sum8}, exp);
      end
      @(posedge clk); #1;
      n_checks++;
      if (ov8 !== exp_ov) begin
        n_fail++; $display("FAIL rand_valid got=%b want=%b", ov8, exp_ov);
      end
      if (exp_ov) begin
        if (sb_q.size() == 0) begin
          n_fail++; n_checks++;
          $display("FAIL rand_scoreboard_empty");
        end else begin
          last_res = sb_q.pop_front();
        end
      end
      n_checks++;
      if ({cq8, sq8} !== last_res) begin
        n_fail++; $display("FAIL rand_reg got=%h want=%h", {cq8, sq8}, last_res);
      end
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL rand_leftover got=%0d want=0", sb_q.size());
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_truth_table();
    test_reg_w1();
    test_boundary_w8();
    test_hold();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
